hazard_unit: RTL and testbench

Stall/flush scheduler for the five-stage MIPS pipeline without forwarding. It tracks destination registers of in-flight instructions in a small scoreboard shift register. Each cycle it compares them against the source registers of the instruction in ID, stalls IF/ID and inserts bubbles into ID/EX on read-after-write hazards. It also squashes wrong-path instructions on taken branches and jumps, and keeps stall/flush performance counters.

---
 rtl/hazard_unit.sv | 98 +++++++++
 tb/tb_hazard_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: RAW stall and branch/jump squash scheduler for a five-stage MIPS pipeline without forwarding.
// Latency: control outputs are combinational in the same cycle; the scoreboard and counters update on clk.
// Backpressure: holds PC and IF/ID and injects ID/EX bubbles while a tracked producer is still in flight.
module hazard_unit #(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [4:0]       id_wr_reg,
    input  logic             id_jump,
    input  logic             ex_br_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [15:0]      flush_events
);

    typedef struct packed {
        logic       v;
        logic [4:0] rgn;
    } sb_ent_t;

    sb_ent_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [15:0]      flush_events_q, flush_events_d;
    logic             track_wb, hit_rs, hit_rt, stall_raw;

    function automatic logic ent_hit(input sb_ent_t e, input logic [4:0] r);
        return e.v && (e.rgn == r) && (r != 5'd0);
    endfunction

    // The WB slot only matters when the register file cannot write-then-read in one cycle.
    assign track_wb = (WB_BYPASS == 0);
    assign hit_rs   = ent_hit(ex_q, id_rs) | ent_hit(mem_q, id_rs) | (track_wb & ent_hit(wb_q, id_rs));
    assign hit_rt   = ent_hit(ex_q, id_rt) | ent_hit(mem_q, id_rt) | (track_wb & ent_hit(wb_q, id_rt));
    assign stall_raw = id_valid & ((id_use_rs & hit_rs) | (id_use_rt & hit_rt));

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall      = 1'b0;
        if (!rst) begin
            if (ex_br_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (stall_raw) begin
                stall      = 1'b1;
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (id_jump) begin
                ifid_flush = 1'b1;
            end
        end
    end

    always_comb begin
        ex_d.v   = id_valid & id_wr_en & (id_wr_reg != 5'd0) & ~stall & ~ex_br_taken;
        ex_d.rgn = id_wr_reg;
        mem_d    = ex_q;
        wb_d     = mem_q;
        stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, stall};
        flush_events_d = flush_events_q + {15'd0, ifid_flush};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q           <= '0;
            mem_q          <= '0;
            wb_q           <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            ex_q           <= ex_d;
            mem_q          <= mem_d;
            wb_q           <= wb_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    // Counters read as zero during reset, before the first reset edge has cleared them.
    assign stall_cycles = rst ? '0 : stall_cycles_q;
    assign flush_events = rst ? '0 : flush_events_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: hand-derived per-cycle expectations queued at drive time, checked at the falling edge.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_jump, ex_br_taken;
    logic [4:0] id_rs, id_rt, id_wr_reg;

    logic        pc_en1, ifid_en1, ifid_flush1, idex_flush1, stall1;
    logic [31:0] sc1;
    logic [15:0] fe1;
    logic        pc_en0, ifid_en0, ifid_flush0, idex_flush0, stall0;
    logic [31:0] sc0;
    logic [15:0] fe0;

    always #5 clk = ~clk;

    hazard_unit #(.WB_BYPASS(1), .CNT_W(32)) dut_byp (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .id_jump(id_jump), .ex_br_taken(ex_br_taken), .pc_en(pc_en1), .ifid_en(ifid_en1),
        .ifid_flush(ifid_flush1), .idex_flush(idex_flush1), .stall(stall1),
        .stall_cycles(sc1), .flush_events(fe1)
    );

    hazard_unit #(.WB_BYPASS(0), .CNT_W(32)) dut_nobyp (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .id_jump(id_jump), .ex_br_taken(ex_br_taken), .pc_en(pc_en0), .ifid_en(ifid_en0),
        .ifid_flush(ifid_flush0), .idex_flush(idex_flush0), .stall(stall0),
        .stall_cycles(sc0), .flush_events(fe0)
    );

    typedef struct {
        string       tag;
        bit          sel;
        logic        es, eiff, eidf;
        logic [31:0] sc, fe;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_sc = 0;
    logic [31:0] exp_fe = 0;
    bit          sel = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic v,
                        input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                        input logic wen, input logic [4:0] wr, input logic jmp, input logic br,
                        input logic es, input logic eiff, input logic eidf);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_wr_en = wen; id_wr_reg = wr; id_jump = jmp; ex_br_taken = br;
        e.tag = tag; e.sel = sel; e.es = es; e.eiff = eiff; e.eidf = eidf;
        e.sc = r ? 32'd0 : exp_sc;
        e.fe = r ? 32'd0 : exp_fe;
        exp_q.push_back(e);
        if (r) begin
            exp_sc = 0;
            exp_fe = 0;
        end else begin
            exp_sc = exp_sc + {31'd0, es};
            exp_fe = exp_fe + {31'd0, eiff};
        end
    endtask

    task automatic bubble(input string tag);
        step(tag, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".stall"},   {31'd0, e.sel ? stall1 : stall0},           {31'd0, e.es});
            chk({e.tag, ".pc_en"},   {31'd0, e.sel ? pc_en1 : pc_en0},           {31'd0, ~e.es});
            chk({e.tag, ".ifid_en"}, {31'd0, e.sel ? ifid_en1 : ifid_en0},       {31'd0, ~e.es});
            chk({e.tag, ".ifid_fl"}, {31'd0, e.sel ? ifid_flush1 : ifid_flush0}, {31'd0, e.eiff});
            chk({e.tag, ".idex_fl"}, {31'd0, e.sel ? idex_flush1 : idex_flush0}, {31'd0, e.eidf});
            chk({e.tag, ".stall_cyc"}, e.sel ? sc1 : sc0, e.sc);
            chk({e.tag, ".flush_ev"},  {16'd0, e.sel ? fe1 : fe0}, e.fe);
        end
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_wr_en = 1'b0; id_wr_reg = '0; id_jump = 1'b0; ex_br_taken = 1'b0;

        // reset with a live-looking reader in ID
        step("rst0", 1, 1, 5'd3, 1, 5'd0, 0, 1, 5'd3, 0, 0, 0, 0, 0);
        step("rst1", 1, 1, 5'd3, 1, 5'd0, 0, 1, 5'd3, 0, 0, 0, 0, 0);
        bubble("post_rst");

        // back-to-back dependency: 2 stall cycles
        step("p3",    0, 1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 0, 0);
        step("c3_s1", 0, 1, 5'd3, 1, 5'd1, 1, 1, 5'd4, 0, 0, 1, 0, 1);
        step("c3_s2", 0, 1, 5'd3, 1, 5'd1, 1, 1, 5'd4, 0, 0, 1, 0, 1);
        step("c3_go", 0, 1, 5'd3, 1, 5'd1, 1, 1, 5'd4, 0, 0, 0, 0, 0);
        bubble("d1a"); bubble("d1b");

        // one independent instruction between: 1 stall cycle
        step("p5",    0, 1, 5'd1, 1, 5'd2, 1, 1, 5'd5, 0, 0, 0, 0, 0);
        step("ind6",  0, 1, 5'd1, 1, 5'd2, 1, 1, 5'd6, 0, 0, 0, 0, 0);
        step("c5_s1", 0, 1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1);
        step("c5_go", 0, 1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        bubble("d2a"); bubble("d2b");

        // $0 never hazards; store data (rt) dependency on a load
        step("ori0",  0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd0, 0, 0, 0, 0, 0);
        step("rd0",   0, 1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0, 0);
        step("lw5",   0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 0, 0, 0, 0, 0);
        step("sw_s1", 0, 1, 5'd2, 1, 5'd5, 1, 0, 5'd0, 0, 0, 1, 0, 1);
        step("sw_s2", 0, 1, 5'd2, 1, 5'd5, 1, 0, 5'd0, 0, 0, 1, 0, 1);
        step("sw_go", 0, 1, 5'd2, 1, 5'd5, 1, 0, 5'd0, 0, 0, 0, 0, 0);
        bubble("d3a"); bubble("d3b");

        // taken branch while the reader is stalled on a MEM producer
        step("p7",    0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd7, 0, 0, 0, 0, 0);
        step("c7_s1", 0, 1, 5'd7, 1, 5'd0, 0, 1, 5'd9, 0, 0, 1, 0, 1);
        step("c7_br", 0, 1, 5'd7, 1, 5'd0, 0, 1, 5'd9, 0, 1, 0, 1, 1);
        step("rd9",   0, 1, 5'd9, 1, 5'd9, 1, 0, 5'd0, 0, 0, 0, 0, 0);
        bubble("d4a"); bubble("d4b");

        // jal then reader of $31
        step("jal",    0, 1, 5'd0, 0, 5'd0, 0, 1, 5'd31, 1, 0, 0, 1, 0);
        step("c31_s1", 0, 1, 5'd31, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1);
        step("c31_s2", 0, 1, 5'd31, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1);
        step("c31_go", 0, 1, 5'd31, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        bubble("d5a"); bubble("d5b");

        // stalled jr-style jump flushes only once the stall clears
        step("p10",   0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd10, 0, 0, 0, 0, 0);
        step("jr_s1", 0, 1, 5'd10, 1, 5'd0, 0, 0, 5'd0, 1, 0, 1, 0, 1);
        step("jr_s2", 0, 1, 5'd10, 1, 5'd0, 0, 0, 5'd0, 1, 0, 1, 0, 1);
        step("jr_go", 0, 1, 5'd10, 1, 5'd0, 0, 0, 5'd0, 1, 0, 0, 1, 0);
        bubble("d6a"); bubble("d6b");

        // reset in the middle of a stall
        step("p11",    0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd11, 0, 0, 0, 0, 0);
        step("c11_s1", 0, 1, 5'd11, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1);
        step("c11_rs", 1, 1, 5'd11, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        step("c11_go", 0, 1, 5'd11, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        bubble("d7a");

        // WB stage tracked: 3 stalls at distance 1, 1 stall at distance 3
        sel = 1'b0;
        step("nb_rst", 1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        bubble("nb_idle");
        step("nb_p12",  0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd12, 0, 0, 0, 0, 0);
        step("nb_c_s1", 0, 1, 5'd12, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1);
        step("nb_c_s2", 0, 1, 5'd12, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1);
        step("nb_c_s3", 0, 1, 5'd12, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1);
        step("nb_c_go", 0, 1, 5'd12, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        bubble("nb_da"); bubble("nb_db"); bubble("nb_dc");
        step("nb_p13",  0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd13, 0, 0, 0, 0, 0);
        step("nb_i1",   0, 1, 5'd2, 1, 5'd0, 0, 1, 5'd14, 0, 0, 0, 0, 0);
        step("nb_i2",   0, 1, 5'd2, 1, 5'd0, 0, 1, 5'd15, 0, 0, 0, 0, 0);
        step("nb_d_s1", 0, 1, 5'd13, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1);
        step("nb_d_go", 0, 1, 5'd13, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        bubble("nb_end");

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
